// File: rtl/button_pkg.sv
// Shared types and default timing constants for the push-button front end.
package button_pkg;

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      PEND_HIGH   = 2'd1,
      STABLE_HIGH = 2'd2,
      PEND_LOW    = 2'd3
   } btn_state_t;

   // 10 ms debounce and 1 s long press at a 50 MHz board clock
   localparam int DEBOUNCE_CYCLES_DEF = 500000;
   localparam int LONG_CYCLES_DEF     = 50000000;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser with synchronous active-low reset.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic s1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1 <= 1'b0;
         q  <= 1'b0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/button_debounce.sv
// Push-button synchroniser + debounce FSM with optional long-press pulse.
// Define BUTTON_LONG_PRESS_EN to compile in the hold counter and o_long_press.
module button_debounce
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic i_button,
   output logic o_button,
   output logic o_busy,
   output logic o_long_press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_cfg
      $error("button_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
   end

   logic          s2;
   btn_state_t    state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (i_button),
      .q     (s2)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= STABLE_LOW;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Any sample back at the old level drops straight to the previous stable state
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         STABLE_LOW: begin
            if (s2) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_nxt = STABLE_HIGH;
               end else begin
                  state_nxt = PEND_HIGH;
                  cnt_nxt   = CW'(1);
               end
            end
         end
         PEND_HIGH: begin
            if (!s2) begin
               state_nxt = STABLE_LOW;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = STABLE_HIGH;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         STABLE_HIGH: begin
            if (!s2) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_nxt = STABLE_LOW;
               end else begin
                  state_nxt = PEND_LOW;
                  cnt_nxt   = CW'(1);
               end
            end
         end
         PEND_LOW: begin
            if (s2) begin
               state_nxt = STABLE_HIGH;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = STABLE_LOW;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = STABLE_LOW;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign o_button = (state == STABLE_HIGH) || (state == PEND_LOW);
   assign o_busy   = (state == PEND_HIGH)   || (state == PEND_LOW);

`ifdef BUTTON_LONG_PRESS_EN
   localparam int HW = $clog2(LONG_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
   localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 1);

   logic [HW-1:0] hold;
   logic          long_q;
   logic          btn_nxt;

   assign btn_nxt = (state_nxt == STABLE_HIGH) || (state_nxt == PEND_LOW);

   // Gating on btn_nxt lets a release on the saturating edge suppress the pulse
   always_ff @(posedge clk) begin
      if (!reset) begin
         hold   <= '0;
         long_q <= 1'b0;
      end else begin
         if (!o_button || !btn_nxt)
            hold <= '0;
         else if (hold != HOLD_MAX)
            hold <= hold + HW'(1);
         long_q <= o_button && btn_nxt && (hold == HOLD_PRE);
      end
   end

   assign o_long_press = long_q;
`else
   assign o_long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed table, corner sequences and random runs
// checked against a run-length reference model of the debounce rules.
module tb_button_debounce;

   localparam int D = 4;
   localparam int L = 10;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic i_button = 1'b0;
   logic o_button, o_busy, o_long_press;

   int n_chk = 0;
   int n_fail = 0;

   button_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_button     (i_button),
      .o_button     (o_button),
      .o_busy       (o_busy),
      .o_long_press (o_long_press)
   );

   always #5 clk = ~clk;

   // Reference model: s2 is the input delayed two edges; the output flips when
   // the last D s2 samples all disagree with it; a long press is exactly L+1
   // consecutive high outputs preceded by a low one.
   bit m_p1, m_p2, m_out, m_busy, m_lp;
   bit s2h[$];
   bit outh[$];

   task automatic model_edge(input bit r, input bit b);
      bit flip;
      bit prev;
      if (!r) begin
         m_p1 = 0; m_p2 = 0; m_out = 0; m_busy = 0; m_lp = 0;
         s2h.delete();  s2h.push_back(1'b0);
         outh.delete(); outh.push_back(1'b0);
      end else begin
         prev = m_out;
         flip = 0;
         if (s2h.size() >= D) begin
            flip = 1;
            for (int k = 0; k < D; k++)
               if (s2h[s2h.size()-1-k] == m_out) flip = 0;
         end
         if (flip) m_out = ~m_out;
         m_busy = (m_out == prev) && (m_p2 != m_out);
         m_p2 = m_p1;
         m_p1 = b;
         s2h.push_back(m_p2);
         outh.push_back(m_out);
         m_lp = 0;
`ifdef BUTTON_LONG_PRESS_EN
         if (outh.size() >= L + 2) begin
            m_lp = (outh[outh.size()-L-2] == 1'b0);
            for (int k = 0; k <= L; k++)
               if (outh[outh.size()-1-k] == 1'b0) m_lp = 0;
         end
`endif
         if (s2h.size() > 64)  void'(s2h.pop_front());
         if (outh.size() > 64) void'(outh.pop_front());
      end
   endtask

   task automatic chk(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic b);
      @(negedge clk);
      reset = r;
      i_button = b;
      @(posedge clk);
      model_edge(r, b);
      #1;
      chk("model_button", o_button, m_out);
      chk("model_busy", o_busy, m_busy);
      chk("model_long", o_long_press, m_lp);
   endtask

   typedef struct packed {
      logic r;
      logic b;
      logic eb;
      logic ey;
      logic el;
   } vec_t;

   vec_t tbl [16];

   initial begin
      int e;
      int k;
      bit seen;

      // reset held with button pressed, then clean press and clean release
      tbl = '{5'b01000, 5'b01000, 5'b01000,
              5'b11000, 5'b11000, 5'b11010, 5'b11010, 5'b11010, 5'b11100, 5'b11100,
              5'b10100, 5'b10100, 5'b10110, 5'b10110, 5'b10110, 5'b10000};
      for (int i = 0; i < 16; i++) begin
         step(tbl[i].r, tbl[i].b);
         chk($sformatf("tbl%0d_button", i), o_button, tbl[i].eb);
         chk($sformatf("tbl%0d_busy", i), o_busy, tbl[i].ey);
         chk($sformatf("tbl%0d_long", i), o_long_press, tbl[i].el);
      end
      repeat (3) step(1'b1, 1'b0);

      // bounce: four 2-cycle levels, then the final rising transition held
      for (int t = 0; t < 4; t++) begin
         repeat (2) begin
            step(1'b1, (t % 2 == 0) ? 1'b1 : 1'b0);
            chk("bounce_low", o_button, 1'b0);
         end
      end
      e = 0;
      do begin step(1'b1, 1'b1); e++; end while (!o_button && e < 20);
      chk_int("bounce_latency", e, D + 2);

      // 3-cycle release glitch must not drop the level
      repeat (2) step(1'b1, 1'b1);
      repeat (3) begin step(1'b1, 1'b0); chk("glitch_hold", o_button, 1'b1); end
      repeat (6) begin step(1'b1, 1'b1); chk("glitch_hold", o_button, 1'b1); end
      chk("glitch_busy_clear", o_busy, 1'b0);

      // clean release, then a long press
      e = 0;
      do begin step(1'b1, 1'b0); e++; end while (o_button && e < 20);
      chk_int("release_latency", e, D + 2);
      repeat (3) step(1'b1, 1'b0);
      e = 0;
      do begin step(1'b1, 1'b1); e++; end while (!o_button && e < 20);
      chk_int("press_latency", e, D + 2);
      k = 0;
      seen = 0;
      while (k < 15 && !seen) begin
         step(1'b1, 1'b1);
         k++;
         if (o_long_press) seen = 1;
      end
`ifdef BUTTON_LONG_PRESS_EN
      chk_int("long_latency", seen ? k : -1, L);
`else
      chk_int("long_absent", int'(seen), 0);
`endif
      repeat (20) begin step(1'b1, 1'b1); chk("long_once", o_long_press, 1'b0); end

      // reset while pending high with the counter at 2
      e = 0;
      do begin step(1'b1, 1'b0); e++; end while (o_button && e < 20);
      repeat (3) step(1'b1, 1'b0);
      repeat (4) step(1'b1, 1'b1);
      chk("pend_busy", o_busy, 1'b1);
      step(1'b0, 1'b1);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_button", o_button, 1'b0);
      e = 0;
      do begin step(1'b1, 1'b1); e++; end while (!o_button && e < 20);
      chk_int("requalify_latency", e, D + 2);

      // random runs with occasional reset
      for (int n = 0; n < 300; n++) begin
         logic lvl;
         int   run;
         lvl = 1'($urandom_range(0, 1));
         run = int'($urandom_range(1, 8));
         if ($urandom_range(0, 49) == 0) step(1'b0, lvl);
         for (int j = 0; j < run; j++) step(1'b1, lvl);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
